// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter table plus tagged BTB on the fetch side,
// RV32I branch resolution, misprediction redirect and one-clock-later training on execute.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_BITS   = 0,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           f_pc,
    output logic                  f_pred_taken,
    output logic [31:0]           f_pred_target,
    output logic [INDEX_BITS-1:0] f_idx,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_zero,
    input  logic                  ex_sign,
    input  logic                  ex_overflow,
    input  logic                  ex_carry,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    input  logic [INDEX_BITS-1:0] ex_idx,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic                  ex_taken,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic                  illegal_branch,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    // Keep at least one history bit so the bimodal build still has a legal vector.
    localparam int unsigned GhrW    = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam bit          UseGhr  = (GHR_BITS > 0);

    logic [1:0]            cnt_q       [Entries];
    logic [Entries-1:0]    btb_valid_q;
    logic [TAG_BITS-1:0]   btb_tag_q   [Entries];
    logic [31:0]           btb_tgt_q   [Entries];
    logic [GhrW-1:0]       ghr_q, ghr_d;
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  btb_hit;
    logic                  act, legal, cond, train;
    logic [1:0]            cnt_cur, cnt_new;

    // Fetch-side lookup; reset forces empty-table behaviour before the first edge.
    always_comb begin
        ghr_ext       = (UseGhr && rst_n) ? INDEX_BITS'(ghr_q) : '0;
        f_idx         = f_pc[INDEX_BITS+1:2] ^ ghr_ext;
        f_tag         = f_pc[INDEX_BITS+2 +: TAG_BITS];
        btb_hit       = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
        f_pred_taken  = rst_n & cnt_q[f_idx][1] & btb_hit;
        f_pred_target = f_pred_taken ? btb_tgt_q[f_idx] : f_pc + 32'd4;
    end

    // Execute-side resolution and training next-state.
    always_comb begin
        act   = ex_valid & ex_branch;
        cond  = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:  cond = ex_zero;
            3'b001:  cond = ~ex_zero;
            3'b100:  cond = ex_sign ^ ex_overflow;
            3'b101:  cond = ~(ex_sign ^ ex_overflow);
            3'b110:  cond = ex_carry;
            3'b111:  cond = ~ex_carry;
            default: legal = 1'b0;
        endcase
        ex_taken       = act & legal & cond;
        illegal_branch = act & ~legal;
        mispredict     = act & ((ex_taken != ex_pred_taken) |
                                (ex_taken & (ex_pred_target != ex_target)));
        redirect_pc    = ex_taken ? ex_target : ex_pc + 32'd4;
        train          = act & legal;

        cnt_cur = cnt_q[ex_idx];
        cnt_new = cnt_cur;
        if (ex_taken && cnt_cur != 2'b11) begin
            cnt_new = cnt_cur + 2'b01;
        end else if (!ex_taken && cnt_cur != 2'b00) begin
            cnt_new = cnt_cur - 2'b01;
        end

        ghr_d = UseGhr ? ((ghr_q << 1) | GhrW'(ex_taken)) : '0;

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (act && branch_cnt_q != 32'hFFFF_FFFF) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && mispred_cnt_q != 32'hFFFF_FFFF) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) begin
                cnt_q[i] <= 2'b01;
            end
            btb_valid_q   <= '0;
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (train) begin
                cnt_q[ex_idx] <= cnt_new;
                ghr_q         <= ghr_d;
                if (ex_taken) begin
                    btb_valid_q[ex_idx] <= 1'b1;
                end
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // BTB payload needs no reset: it is only observed behind btb_valid_q.
    always_ff @(posedge clk) begin
        if (rst_n && train && ex_taken) begin
            btb_tag_q[ex_idx] <= ex_pc[INDEX_BITS+2 +: TAG_BITS];
            btb_tgt_q[ex_idx] <= ex_target;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance and a gshare (GHR_BITS=4) instance
// share fetch/execute stimulus; each carries its own fetch index and prediction.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        ex_valid, ex_branch;
    logic [2:0]  ex_funct3;
    logic        ex_zero, ex_sign, ex_overflow, ex_carry;
    logic [31:0] ex_pc, ex_target;

    logic [5:0]  b_ex_idx, g_ex_idx;
    logic        b_ex_pred_taken, g_ex_pred_taken;
    logic [31:0] b_ex_pred_target, g_ex_pred_target;

    logic        b_f_pred_taken, g_f_pred_taken;
    logic [31:0] b_f_pred_target, g_f_pred_target;
    logic [5:0]  b_f_idx, g_f_idx;
    logic        b_ex_taken, g_ex_taken, b_mispredict, g_mispredict;
    logic [31:0] b_redirect_pc, g_redirect_pc;
    logic        b_illegal, g_illegal;
    logic [31:0] b_branch_count, g_branch_count, b_mp_count, g_mp_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .GHR_BITS(0), .TAG_BITS(8)) u_bimodal (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
        .f_pred_taken(b_f_pred_taken), .f_pred_target(b_f_pred_target), .f_idx(b_f_idx),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_zero(ex_zero), .ex_sign(ex_sign), .ex_overflow(ex_overflow), .ex_carry(ex_carry),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_idx(b_ex_idx),
        .ex_pred_taken(b_ex_pred_taken), .ex_pred_target(b_ex_pred_target),
        .ex_taken(b_ex_taken), .mispredict(b_mispredict), .redirect_pc(b_redirect_pc),
        .illegal_branch(b_illegal), .branch_count(b_branch_count),
        .mispredict_count(b_mp_count)
    );

    branch_predictor #(.INDEX_BITS(6), .GHR_BITS(4), .TAG_BITS(8)) u_gshare (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
        .f_pred_taken(g_f_pred_taken), .f_pred_target(g_f_pred_target), .f_idx(g_f_idx),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_zero(ex_zero), .ex_sign(ex_sign), .ex_overflow(ex_overflow), .ex_carry(ex_carry),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_idx(g_ex_idx),
        .ex_pred_taken(g_ex_pred_taken), .ex_pred_target(g_ex_pred_target),
        .ex_taken(g_ex_taken), .mispredict(g_mispredict), .redirect_pc(g_redirect_pc),
        .illegal_branch(g_illegal), .branch_count(g_branch_count),
        .mispredict_count(g_mp_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {zero, sign, overflow, carry}; bimodal index derived from the PC by hand.
    task automatic set_ex(input logic v, input logic [2:0] f3, input logic [3:0] flags,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
        ex_valid         = v;
        ex_branch        = 1'b1;
        ex_funct3        = f3;
        {ex_zero, ex_sign, ex_overflow, ex_carry} = flags;
        ex_pc            = pc;
        ex_target        = tgt;
        b_ex_idx         = pc[7:2];
        b_ex_pred_taken  = pt;
        b_ex_pred_target = ptgt;
        #1;
    endtask

    function automatic logic br_model(input logic [2:0] f3, input logic [3:0] fl);
        logic z, s, o, c;
        {z, s, o, c} = fl;
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return s != o;
            3'd5:    return s == o;
            3'd6:    return c;
            3'd7:    return !c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        f_pc  = 32'h100;
        g_ex_idx = '0; g_ex_pred_taken = 1'b0; g_ex_pred_target = '0;
        set_ex(1'b0, 3'd0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset state
        tick();
        check_val("rst_pred_taken", {31'd0, b_f_pred_taken}, 32'd0);
        check_val("rst_pred_target", b_f_pred_target, 32'h104);
        check_val("rst_branch_count", b_branch_count, 32'd0);
        check_val("rst_mp_count", b_mp_count, 32'd0);
        rst_n = 1'b1;

        // Training: BEQ taken twice at 0x200 with not-taken prediction
        for (int k = 0; k < 2; k++) begin
            set_ex(1'b1, 3'd0, 4'b1000, 32'h200, 32'h80, 1'b0, 32'h204);
            check_val("train_mispredict", {31'd0, b_mispredict}, 32'd1);
            check_val("train_redirect", b_redirect_pc, 32'h80);
            tick();
        end
        ex_valid = 1'b0;
        f_pc = 32'h200; #1;
        check_val("train_pred_taken", {31'd0, b_f_pred_taken}, 32'd1);
        check_val("train_pred_target", b_f_pred_target, 32'h80);
        check_val("train_branch_count", b_branch_count, 32'd2);
        check_val("train_mp_count", b_mp_count, 32'd2);
        // Same index, different tag: no false hit
        f_pc = 32'h300; #1;
        check_val("alias_pred_taken", {31'd0, b_f_pred_taken}, 32'd0);
        check_val("alias_pred_target", b_f_pred_target, 32'h304);

        // act=0 suppresses everything
        set_ex(1'b0, 3'd0, 4'b1000, 32'h200, 32'h80, 1'b0, 32'h204);
        check_val("idle_taken", {31'd0, b_ex_taken}, 32'd0);
        check_val("idle_mispredict", {31'd0, b_mispredict}, 32'd0);

        // Saturation: 4 taken, then not-taken once (still taken), twice (not taken)
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b1, 3'd0, 4'b1000, 32'h200, 32'h80, 1'b1, 32'h80);
            tick();
        end
        set_ex(1'b1, 3'd0, 4'b0000, 32'h200, 32'h80, 1'b1, 32'h80);
        check_val("sat_nt_redirect", b_redirect_pc, 32'h204);
        tick();
        ex_valid = 1'b0; f_pc = 32'h200; #1;
        check_val("sat_one_nt_target", b_f_pred_target, 32'h80);
        set_ex(1'b1, 3'd0, 4'b0000, 32'h200, 32'h80, 1'b1, 32'h80);
        tick();
        ex_valid = 1'b0; #1;
        check_val("sat_two_nt_taken", {31'd0, b_f_pred_taken}, 32'd0);
        check_val("sat_two_nt_target", b_f_pred_target, 32'h204);

        // Flag decode sweep on a spare index
        for (int f = 0; f < 8; f++) begin
            if (f == 2 || f == 3) continue;
            for (int fl = 0; fl < 16; fl++) begin
                set_ex(1'b1, 3'(f), 4'(fl), 32'h4FC, 32'h500, 1'b0, 32'h0);
                check_val($sformatf("decode_f%0d_fl%0h", f, fl), {31'd0, b_ex_taken},
                          {31'd0, br_model(3'(f), 4'(fl))});
                tick();
            end
        end

        // Illegal funct3 leaves tables alone but still counts
        do_reset();
        set_ex(1'b1, 3'd0, 4'b1000, 32'h200, 32'h80, 1'b0, 32'h204);
        tick();
        set_ex(1'b1, 3'b010, 4'b1000, 32'h200, 32'h80, 1'b0, 32'h204);
        check_val("illegal_flag", {31'd0, b_illegal}, 32'd1);
        check_val("illegal_taken", {31'd0, b_ex_taken}, 32'd0);
        tick();
        ex_valid = 1'b0; f_pc = 32'h200; #1;
        check_val("illegal_pred_kept", {31'd0, b_f_pred_taken}, 32'd1);
        check_val("illegal_branch_count", b_branch_count, 32'd2);
        check_val("illegal_mp_count", b_mp_count, 32'd1);

        // Target mismatch at 0x240
        set_ex(1'b1, 3'd0, 4'b1000, 32'h240, 32'h300, 1'b0, 32'h244);
        tick();
        ex_valid = 1'b0; f_pc = 32'h240; #1;
        check_val("tgt_first_target", b_f_pred_target, 32'h300);
        set_ex(1'b1, 3'd0, 4'b1000, 32'h240, 32'h340, 1'b1, 32'h300);
        check_val("tgt_mispredict", {31'd0, b_mispredict}, 32'd1);
        check_val("tgt_redirect", b_redirect_pc, 32'h340);
        tick();
        ex_valid = 1'b0; #1;
        check_val("tgt_updated", b_f_pred_target, 32'h340);
        // Predicted taken, resolves not taken (BNE with zero=1)
        set_ex(1'b1, 3'd1, 4'b1000, 32'h240, 32'h340, 1'b1, 32'h340);
        check_val("nt_mispredict", {31'd0, b_mispredict}, 32'd1);
        check_val("nt_redirect", b_redirect_pc, 32'h244);
        tick();

        // gshare: alternating T/N at 0x200; mispredicts stop after six iterations
        do_reset();
        f_pc = 32'h200;
        for (int i = 0; i < 40; i++) begin
            #1;
            g_ex_idx         = g_f_idx;
            g_ex_pred_taken  = g_f_pred_taken;
            g_ex_pred_target = g_f_pred_target;
            set_ex(1'b1, 3'd0, (i % 2 == 0) ? 4'b1000 : 4'b0000, 32'h200, 32'h80,
                   1'b0, 32'h204);
            if (i >= 6) begin
                check_val($sformatf("gshare_mp_%0d", i), {31'd0, g_mispredict}, 32'd0);
            end
            tick();
        end
        ex_valid = 1'b0; #1;
        check_val("gshare_mp_count", g_mp_count, 32'd3);
        check_val("gshare_branch_count", g_branch_count, 32'd40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
